conv2_k_mem_write: RTL

- Loader that fills the Convolution 2 layer weight memory with 6 kernels of 25 weights each (150 words, addresses 0..149).
- Takes a valid/ready weight stream from the host-side bus interface and produces registered write-enable, address and data for the weight RAM.
- Asserts done once the full set is written, so the conv2 read-side address counter can be enabled.

---
 rtl/conv_pkg.sv | 14 +
 rtl/kidx_counter.sv | 46 ++++
 rtl/conv2_k_mem_write.sv | 80 ++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared conv2 weight-loader constants, types and FSM states
package conv_pkg;
  localparam int CONV2_KSIZE      = 25;
  localparam int CONV2_NKERN      = 6;
  localparam int CONV2_KMEM_DEPTH = CONV2_KSIZE * CONV2_NKERN;

  typedef logic [15:0] weight_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } kload_state_t;
endpackage

// File: rtl/kidx_counter.sv
// rtl/kidx_counter.sv - element/kernel wrap counter with running base address
module kidx_counter #(
  parameter int KSIZE  = 25,
  parameter int NKERN  = 6,
  parameter int ADDR_W = 8,
  parameter int KIDX_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [KIDX_W-1:0] kern_idx,
  output logic              last
);
  localparam int EW = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  logic [EW-1:0]     elem;
  logic [ADDR_W-1:0] base;
  logic              last_elem;
  logic              last_kern;

  assign last_elem = (elem == EW'(KSIZE - 1));
  assign last_kern = (kern_idx == KIDX_W'(NKERN - 1));
  assign last      = last_elem && last_kern;
  assign addr      = base + ADDR_W'(elem);

  // base tracks kern_idx*KSIZE incrementally; the final kernel holds its index
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      elem     <= '0;
      kern_idx <= '0;
      base     <= '0;
    end else if (advance) begin
      if (last_elem) begin
        elem <= '0;
        if (!last_kern) begin
          kern_idx <= kern_idx + 1'b1;
          base     <= base + ADDR_W'(KSIZE);
        end
      end else begin
        elem <= elem + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv2_k_mem_write.sv
// rtl/conv2_k_mem_write.sv - streams 6x25 conv2 weights into the weight RAM
module conv2_k_mem_write
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KSIZE  = CONV2_KSIZE,
  parameter int NKERN  = CONV2_NKERN,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [2:0]        kern_idx,
  output logic              done
);
  kload_state_t      state, state_next;
  logic              accept;
  logic              wr;
  logic              last;
  logic [ADDR_W-1:0] cnt_addr;

  assign accept = in_valid && in_ready;
  // a beat coinciding with start belongs to the abandoned load
  assign wr     = accept && !start;
  assign done   = (state == DONE);

  kidx_counter #(
    .KSIZE (KSIZE),
    .NKERN (NKERN),
    .ADDR_W(ADDR_W),
    .KIDX_W(3)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .advance (wr),
    .addr    (cnt_addr),
    .kern_idx(kern_idx),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (!start && accept && last) state_next = DONE;
      end
      DONE: if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= wr;
      if (wr) begin
        waddr <= cnt_addr;
        wdata <= in_data;
      end
    end
  end
endmodule
